warp_dispatcher: RTL and testbench

Kernel launch controller in front of streaming_multiprocessor. Accepts one launch request (start PC, thread count) and splits it into warps. Assigns each warp to a free warp slot by writing its state, PC and active mask, one slot per cycle. It then tracks EXIT reports from the SM and pulses kernel_done once every dispatched warp has retired.

---
 rtl/warp_dispatcher.sv | 210 +++++++++++++++++++++
 tb/tb_warp_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_dispatcher.sv
// Kernel launch controller: splits one launch into warps, hands each warp to the
// lowest free SM slot (one per cycle), and pulses kernel_done once every issued
// warp has reported EXIT.
// Optional build macro WARP_DISPATCH_PERF_EN adds the kernel_cycles counter port.
module warp_dispatcher #(
    parameter int unsigned NUM_WARPS = 24,
    parameter int unsigned WARP_SIZE = 32,
    parameter int unsigned PC_W      = 8,
    parameter int unsigned THR_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         launch_valid,
    output logic                         launch_ready,
    input  logic [PC_W-1:0]              launch_pc,
    input  logic [THR_W-1:0]             launch_threads,
    output logic                         init_valid,
    output logic [$clog2(NUM_WARPS)-1:0] init_warp,
    output logic [PC_W-1:0]              init_pc,
    output logic [WARP_SIZE-1:0]         init_mask,
    input  logic                         exit_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] exit_warp,
    output logic                         busy,
    output logic                         kernel_done,
    output logic                         exit_err
`ifdef WARP_DISPATCH_PERF_EN
    ,
    output logic [31:0]                  kernel_cycles
`endif
);

    localparam int unsigned WID     = $clog2(NUM_WARPS);
    localparam int unsigned LOG2_WS = $clog2(WARP_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StDrain,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [THR_W-1:0]       warps_total_q, warps_total_d;
    logic [WARP_SIZE-1:0]   tail_mask_q, tail_mask_d;
    logic [THR_W-1:0]       dispatched_q, dispatched_d;
    logic [THR_W-1:0]       retired_q, retired_d;
    logic [NUM_WARPS-1:0]   free_q, free_d;
    logic                   exit_err_q, exit_err_d;
    logic                   kernel_done_q;

    logic                   alloc_found;
    logic [WID-1:0]         alloc_idx;
    logic                   exit_in_range;
    logic                   exit_hit;
    logic                   exit_bad;
    logic                   last_warp;
    logic [THR_W:0]         thr_round;
    logic [THR_W:0]         thr_warps;
    logic [THR_W-1:0]       thr_rem;
    logic [WARP_SIZE-1:0]   launch_tail;

    // Lowest-index free slot, taken from the registered bitmap only.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = int'(NUM_WARPS) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = WID'(i);
            end
        end
    end

    // Launch decode: ceil(threads / WARP_SIZE) by shift, and the partial tail mask.
    always_comb begin
        thr_round   = {1'b0, launch_threads} + (THR_W + 1)'(WARP_SIZE - 1);
        thr_warps   = thr_round >> LOG2_WS;
        thr_rem     = launch_threads & THR_W'(WARP_SIZE - 1);
        launch_tail = (thr_rem == '0) ? '1 : ~({WARP_SIZE{1'b1}} << thr_rem);
    end

    // Exit classification; out-of-range slot numbers count as unallocated.
    always_comb begin
        exit_in_range = (32'(exit_warp) < NUM_WARPS);
        exit_hit      = exit_valid && exit_in_range && !free_q[exit_warp];
        exit_bad      = exit_valid && !exit_hit;
        last_warp     = (dispatched_q == (warps_total_q - THR_W'(1)));
    end

    // Next-state and output logic; exits and allocation touch disjoint bitmap bits.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        warps_total_d = warps_total_q;
        tail_mask_d   = tail_mask_q;
        dispatched_d  = dispatched_q;
        retired_d     = retired_q;
        free_d        = free_q;
        exit_err_d    = exit_err_q;
        launch_ready  = 1'b0;
        init_valid    = 1'b0;
        init_warp     = '0;
        init_pc       = '0;
        init_mask     = '0;

        if (exit_hit) begin
            free_d[exit_warp] = 1'b1;
            retired_d         = retired_q + THR_W'(1);
        end
        if (exit_bad) begin
            exit_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                launch_ready = 1'b1;
                if (launch_valid) begin
                    pc_d          = launch_pc;
                    warps_total_d = thr_warps[THR_W-1:0];
                    tail_mask_d   = launch_tail;
                    dispatched_d  = '0;
                    retired_d     = '0;
                    state_d       = (launch_threads == '0) ? StDone : StDispatch;
                end
            end
            StDispatch: begin
                if (alloc_found) begin
                    init_valid        = 1'b1;
                    init_warp         = alloc_idx;
                    init_pc           = pc_q;
                    init_mask         = last_warp ? tail_mask_q : '1;
                    free_d[alloc_idx] = 1'b0;
                    dispatched_d      = dispatched_q + THR_W'(1);
                    if (last_warp) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (retired_q == warps_total_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            warps_total_q <= '0;
            tail_mask_q   <= '0;
            dispatched_q  <= '0;
            retired_q     <= '0;
            free_q        <= '1;
            exit_err_q    <= 1'b0;
            kernel_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            warps_total_q <= warps_total_d;
            tail_mask_q   <= tail_mask_d;
            dispatched_q  <= dispatched_d;
            retired_q     <= retired_d;
            free_q        <= free_d;
            exit_err_q    <= exit_err_d;
            kernel_done_q <= (state_q == StDone);
        end
    end

    assign busy        = (state_q != StIdle);
    assign kernel_done = kernel_done_q;
    assign exit_err    = exit_err_q;

`ifdef WARP_DISPATCH_PERF_EN
    logic [31:0] cycles_q;
    logic        run_q;

    // Cycle count from the accepting cycle through the kernel_done cycle, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
            run_q    <= 1'b0;
        end else if ((state_q == StIdle) && launch_valid) begin
            cycles_q <= 32'd1;
            run_q    <= 1'b1;
        end else if (run_q) begin
            if (cycles_q != '1) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if (kernel_done_q) begin
                run_q <= 1'b0;
            end
        end
    end

    assign kernel_cycles = cycles_q;
`else
    // Cycle counter not built.
`endif

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed self-checking bench for warp_dispatcher (default parameters).
module tb_warp_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        launch_valid;
    logic        launch_ready;
    logic [7:0]  launch_pc;
    logic [15:0] launch_threads;
    logic        init_valid;
    logic [4:0]  init_warp;
    logic [7:0]  init_pc;
    logic [31:0] init_mask;
    logic        exit_valid;
    logic [4:0]  exit_warp;
    logic        busy;
    logic        kernel_done;
    logic        exit_err;

    int checks;
    int errors;

    warp_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .launch_valid   (launch_valid),
        .launch_ready   (launch_ready),
        .launch_pc      (launch_pc),
        .launch_threads (launch_threads),
        .init_valid     (init_valid),
        .init_warp      (init_warp),
        .init_pc        (init_pc),
        .init_mask      (init_mask),
        .exit_valid     (exit_valid),
        .exit_warp      (exit_warp),
        .busy           (busy),
        .kernel_done    (kernel_done),
        .exit_err       (exit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a launch in the current cycle; returns just after the accepting edge.
    task automatic launch(input logic [7:0] pc, input logic [15:0] thr);
        launch_valid   = 1'b1;
        launch_pc      = pc;
        launch_threads = thr;
        checks++;
        if (launch_ready !== 1'b1) begin
            errors++;
            $display("FAIL launch_ready_before_launch: got %b want 1", launch_ready);
        end
        step();
        launch_valid = 1'b0;
    endtask

    task automatic do_exit(input logic [4:0] w);
        exit_valid = 1'b1;
        exit_warp  = w;
        step();
        exit_valid = 1'b0;
    endtask

    // Cycles until kernel_done is seen, -1 if it never shows within the budget.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            if (kernel_done === 1'b1) begin
                n = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        launch_valid   = 1'b0;
        launch_pc      = '0;
        launch_threads = '0;
        exit_valid     = 1'b0;
        exit_warp      = '0;
        #2;
        checks++;
        if ({launch_ready, init_valid, busy, kernel_done, exit_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 10000",
                     {launch_ready, init_valid, busy, kernel_done, exit_err});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        launch(8'h00, 16'd32);
        checks++;
        if ({init_valid, init_warp, init_pc, init_mask} !== {1'b1, 5'd0, 8'h00, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL single_init: got v=%b w=%0d pc=%h m=%h want v=1 w=0 pc=00 m=ffffffff",
                     init_valid, init_warp, init_pc, init_mask);
        end
        checks++;
        if ({launch_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL single_busy: got ready=%b busy=%b want ready=0 busy=1",
                     launch_ready, busy);
        end
        step();
        step();
        checks++;
        if ({init_valid, kernel_done} !== 2'b00) begin
            errors++;
            $display("FAIL single_drain: got init_valid=%b done=%b want 0 0",
                     init_valid, kernel_done);
        end
        do_exit(5'd0);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL single_done_latency: got %0d want 2", n);
        end
        step();
        checks++;
        if ({kernel_done, launch_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL single_after_done: got done=%b ready=%b busy=%b want 0 1 0",
                     kernel_done, launch_ready, busy);
        end
    endtask

    task automatic test_two_warps();
        int n;
        launch(8'h3C, 16'd40);
        checks++;
        if ({init_valid, init_warp, init_pc, init_mask} !== {1'b1, 5'd0, 8'h3C, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL two_init0: got v=%b w=%0d pc=%h m=%h want v=1 w=0 pc=3c m=ffffffff",
                     init_valid, init_warp, init_pc, init_mask);
        end
        step();
        checks++;
        if ({init_valid, init_warp, init_pc, init_mask} !== {1'b1, 5'd1, 8'h3C, 32'h0000_00FF}) begin
            errors++;
            $display("FAIL two_init1: got v=%b w=%0d pc=%h m=%h want v=1 w=1 pc=3c m=000000ff",
                     init_valid, init_warp, init_pc, init_mask);
        end
        step();
        checks++;
        if (init_valid !== 1'b0) begin
            errors++;
            $display("FAIL two_no_third_init: got %b want 0", init_valid);
        end
        // Exits in reverse order; one exit alone must not finish the kernel.
        do_exit(5'd1);
        step();
        step();
        checks++;
        if ({kernel_done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL two_partial_retire: got done=%b busy=%b want 0 1", kernel_done, busy);
        end
        do_exit(5'd0);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL two_done_latency: got %0d want 2", n);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        int bad;
        bad = 0;
        launch(8'h10, 16'd800);
        for (int i = 0; i < 24; i++) begin
            if (!(init_valid === 1'b1 && init_warp === 5'(i) && init_mask === 32'hFFFF_FFFF
                  && init_pc === 8'h10)) begin
                bad++;
            end
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL big_24_inits: got %0d bad cycles want 0", bad);
        end
        step();
        checks++;
        if ({init_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL big_stall: got init_valid=%b busy=%b want 0 1", init_valid, busy);
        end
        do_exit(5'd5);
        checks++;
        if ({init_valid, init_warp, init_mask} !== {1'b1, 5'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL big_recycle: got v=%b w=%0d m=%h want v=1 w=5 m=ffffffff",
                     init_valid, init_warp, init_mask);
        end
        step();
        for (int i = 0; i < 23; i++) begin
            do_exit(5'(i));
        end
        step();
        checks++;
        if ({kernel_done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL big_24_of_25: got done=%b busy=%b want 0 1", kernel_done, busy);
        end
        do_exit(5'd23);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL big_done_latency: got %0d want 2", n);
        end
        step();
    endtask

    task automatic test_zero_threads();
        int n;
        launch(8'h44, 16'd0);
        checks++;
        if ({init_valid, kernel_done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL zero_first_cycle: got v=%b done=%b busy=%b want 0 0 1",
                     init_valid, kernel_done, busy);
        end
        step();
        checks++;
        if ({init_valid, kernel_done} !== 2'b01) begin
            errors++;
            $display("FAIL zero_done_pulse: got v=%b done=%b want 0 1", init_valid, kernel_done);
        end
        step();
        checks++;
        if ({kernel_done, launch_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_after: got done=%b ready=%b want 0 1", kernel_done, launch_ready);
        end
        n = 0;
    endtask

    task automatic test_exit_err();
        int n;
        launch(8'h21, 16'd32);
        step();
        step();
        do_exit(5'd10);
        checks++;
        if (exit_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", exit_err);
        end
        step();
        step();
        step();
        checks++;
        if ({kernel_done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_no_retire: got done=%b busy=%b want 0 1", kernel_done, busy);
        end
        do_exit(5'd0);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL err_done_latency: got %0d want 2", n);
        end
        step();
        checks++;
        if (exit_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", exit_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        launch(8'h07, 16'd100);
        step();
        checks++;
        if ({init_valid, init_warp} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL mid_dispatching: got v=%b w=%0d want v=1 w=1", init_valid, init_warp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({launch_ready, init_valid, busy, kernel_done, exit_err} !== 5'b10000) begin
            errors++;
            $display("FAIL mid_async_reset: got %b want 10000",
                     {launch_ready, init_valid, busy, kernel_done, exit_err});
        end
        step();
        rst_n = 1'b1;
        step();
        launch(8'h09, 16'd32);
        checks++;
        if ({init_valid, init_warp, init_pc, init_mask} !== {1'b1, 5'd0, 8'h09, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL mid_relaunch: got v=%b w=%0d pc=%h m=%h want v=1 w=0 pc=09 m=ffffffff",
                     init_valid, init_warp, init_pc, init_mask);
        end
        step();
        do_exit(5'd0);
        wait_done(n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL mid_relaunch_done: got %0d want 2", n);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_two_warps();
        test_back_to_back();
        test_zero_threads();
        test_exit_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
